load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake bundle for the load/store unit.
// master: core driving requests; slave: the unit answering them.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned,
    output req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned,
    input  req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time to a word-wide data memory.
// Ports: clk, res (sync, active high), bus (load_store_unit_if.slave),
//   mem_addr/mem_wdata/mem_we/mem_re out, mem_rdata in.
// Macro LSU_SUBWORD_EN enables byte/half accesses (word-only otherwise).
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              res,
  load_store_unit_if.slave  bus,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        uns_q;
  logic        err_q;
  logic        accept;
  logic        bad;
  logic        sz_bad;
  logic        al_bad;
  logic        rng_bad;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (size)
      2'b00:   extract = uns ? {24'h0, s[7:0]}
                             : {{24{s[7]}}, s[7:0]};
      2'b01:   extract = uns ? {16'h0, s[15:0]}
                             : {{16{s[15]}}, s[15:0]};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the old word.
  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  lane,
    input logic [1:0]  size
  );
    logic [31:0] m;
    logic [4:0]  sh;
    case (size)
      2'b00:   m = 32'h0000_00ff;
      2'b01:   m = 32'h0000_ffff;
      default: m = 32'hffff_ffff;
    endcase
    sh = {lane, 3'b000};
    merge = (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  always_comb begin
`ifdef LSU_SUBWORD_EN
    sz_bad = (bus.req_size == 2'b11);
`else
    sz_bad = (bus.req_size != 2'b10);
`endif
    al_bad = unique0_al(bus.req_size, bus.req_addr[1:0]);
    rng_bad = {2'b00, bus.req_addr[31:2]} >= MEM_WORDS;
    bad = sz_bad | al_bad | rng_bad;
  end

  function automatic logic unique0_al(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    unique0_al = 1'b0;
    unique case (1'b1)
      (size == 2'b01): unique0_al = lo[0];
      (size == 2'b10): unique0_al = (lo != 2'b00);
      default:         unique0_al = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_nx       = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_err   = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bad)
            state_nx = RESP;
          else if (!bus.req_write)
            state_nx = RD;
          else if (bus.req_size == 2'b10)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD: begin
        mem_re   = 1'b1;
        mem_addr = {2'b00, addr_q[31:2]};
        state_nx = write_q ? WR : RESP;
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = {2'b00, addr_q[31:2]};
        mem_wdata = merge(buf_q, wdata_q, addr_q[1:0], size_q);
        state_nx  = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        if (bus.resp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset must suppress any memory access in the same cycle.
    if (res) begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'h0;
      bus.resp_err   = 1'b0;
      mem_addr       = 32'h0;
      mem_wdata      = 32'h0;
      mem_we         = 1'b0;
      mem_re         = 1'b0;
    end
  end

  assign accept = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      rdata_q <= 32'h0;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        write_q <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        err_q   <= bad;
        rdata_q <= 32'h0;
      end
      if (state == RD) begin
        buf_q <= mem_rdata;
        if (!write_q)
          rdata_q <= extract(mem_rdata, addr_q[1:0],
                             size_q, uns_q);
      end
    end
  end

endmodule
